// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - UART-driven load/run/step/dump controller for the MIPS debug port
// Loads instruction words, gates pipeline execution and serialises PC/registers/memory to the host.
module debug_controller #(
  parameter int                   INST_SZ   = 32,
  parameter int                   PC_SZ     = 32,
  parameter int                   REG_SZ    = 5,
  parameter int                   BYTE_SZ   = 8,
  parameter logic [INST_SZ-1:0]   HALT_INST = 32'hFFFF_FFFF,
  parameter logic [BYTE_SZ-1:0]   CMD_LOAD  = 8'h4C,
  parameter logic [BYTE_SZ-1:0]   CMD_RUN   = 8'h43,
  parameter logic [BYTE_SZ-1:0]   CMD_STEP  = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic               i_halt,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [2:0]         o_state
);

  localparam int BYTES      = INST_SZ / BYTE_SZ;
  localparam int BCNT_W     = $clog2(BYTES);
  localparam int NREGS      = 1 << REG_SZ;
  localparam int DUMP_WORDS = 1 + 2 * NREGS;
  localparam int WCNT_W     = $clog2(DUMP_WORDS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RUN        = 3'd2,
    S_STEP       = 3'd3,
    S_DUMP_ADDR  = 3'd4,
    S_DUMP_LATCH = 3'd5,
    S_DUMP_SEND  = 3'd6,
    S_DUMP_WAIT  = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [INST_SZ-1:0]  shift_q, shift_d;
  logic [INST_SZ-1:0]  instr_q, instr_d;
  logic                write_q, write_d;
  logic                enable_q, enable_d;
  logic [REG_SZ-1:0]   addr_q, addr_d;
  logic [BYTE_SZ-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;

  logic                last_byte;
  logic                last_word;
  logic [INST_SZ-1:0]  load_word;
  logic [INST_SZ-1:0]  dump_word;

  assign last_byte = (byte_cnt_q == BCNT_W'(BYTES - 1));
  assign last_word = (word_cnt_q == WCNT_W'(DUMP_WORDS - 1));
  assign load_word = {shift_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};

  // Word 0 is the PC, then the register file, then data memory.
  always_comb begin
    dump_word = INST_SZ'(i_pc);
    if (word_cnt_q == '0) begin
      dump_word = INST_SZ'(i_pc);
    end else if (word_cnt_q <= WCNT_W'(NREGS)) begin
      dump_word = i_reg;
    end else begin
      dump_word = i_mem;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          case (i_rx_data)
            CMD_LOAD: state_d = S_LOAD;
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (i_rx_done && last_byte && (load_word == HALT_INST)) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_halt) begin
          state_d = S_DUMP_ADDR;
        end
      end
      S_STEP: begin
        // enable_q high means the single step pulse has just been issued.
        if (enable_q || i_halt) begin
          state_d = S_DUMP_ADDR;
        end
      end
      S_DUMP_ADDR:  state_d = S_DUMP_LATCH;
      S_DUMP_LATCH: state_d = S_DUMP_SEND;
      S_DUMP_SEND:  state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte) begin
            state_d = S_DUMP_SEND;
          end else if (last_word) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DUMP_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    instr_d    = instr_q;
    write_d    = 1'b0;
    enable_d   = 1'b0;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (i_rx_done) begin
          shift_d    = load_word;
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + BCNT_W'(1);
          if (last_byte) begin
            instr_d = load_word;
            write_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        enable_d = !i_halt;
      end
      S_STEP: begin
        enable_d = !i_halt && !enable_q;
      end
      S_DUMP_ADDR: begin
        addr_d = (word_cnt_q == '0) ? '0 : REG_SZ'(word_cnt_q - WCNT_W'(1));
      end
      S_DUMP_LATCH: begin
        shift_d = dump_word;
      end
      S_DUMP_SEND: begin
        tx_data_d  = shift_q[INST_SZ-1 -: BYTE_SZ];
        tx_start_d = 1'b1;
      end
      S_DUMP_WAIT: begin
        if (i_tx_done) begin
          shift_d    = shift_q << BYTE_SZ;
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + BCNT_W'(1);
          if (last_byte) begin
            word_cnt_d = last_word ? '0 : word_cnt_q + WCNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      instr_q    <= '0;
      write_q    <= 1'b0;
      enable_q   <= 1'b0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      instr_q    <= instr_d;
      write_q    <= write_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_write       = write_q;
  assign o_enable      = enable_q;
  assign o_debug_addr  = addr_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - randomized self-checking bench for debug_controller
module tb_debug_controller;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h43;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [31:0] i_pc;
  logic [31:0] i_reg;
  logic [31:0] i_mem;
  logic        i_halt = 1'b0;
  logic [31:0] o_instruction;
  logic        o_write;
  logic        o_enable;
  logic [4:0]  o_debug_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [2:0]  o_state;

  logic [31:0] pc_val;
  logic [31:0] reg_tab [32];
  logic [31:0] mem_tab [32];

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int txs_cnt = 0;
  int excl_bad = 0;
  int en_bad = 0;
  logic [31:0] wr_q [$];
  logic [7:0]  exp_q [$];

  assign i_pc  = pc_val;
  assign i_reg = reg_tab[o_debug_addr];
  assign i_mem = mem_tab[o_debug_addr];

  debug_controller dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt),
    .o_instruction(o_instruction), .o_write(o_write), .o_enable(o_enable),
    .o_debug_addr(o_debug_addr), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_write) wr_q.push_back(o_instruction);
    if (o_enable) en_cnt++;
    if (o_tx_start) txs_cnt++;
    if (o_write && o_tx_start) excl_bad++;
    if (o_enable && o_state != 3'd2 && o_state != 3'd3) en_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic set_ident_tables();
    pc_val = 32'h4;
    for (int i = 0; i < 32; i++) begin
      reg_tab[i] = 32'(i);
      mem_tab[i] = ~32'(i);
    end
  endtask

  task automatic set_random_tables();
    pc_val = $urandom;
    for (int i = 0; i < 32; i++) begin
      reg_tab[i] = $urandom;
      mem_tab[i] = $urandom;
    end
  endtask

  // Expected dump: PC, reg[0..31], mem[0..31], each word MSB byte first.
  task automatic build_exp();
    logic [31:0] words [$];
    exp_q.delete();
    words.push_back(pc_val);
    for (int i = 0; i < 32; i++) words.push_back(reg_tab[i]);
    for (int i = 0; i < 32; i++) words.push_back(mem_tab[i]);
    foreach (words[w]) begin
      for (int k = 3; k >= 0; k--) exp_q.push_back(words[w][k*8 +: 8]);
    end
  endtask

  task automatic do_dump(input int dmin, input int dmax, input bit spur, input int stop_at);
    int t0;
    int bad;
    int d;
    bit seen;
    logic [7:0] b;
    t0 = txs_cnt;
    bad = 0;
    build_exp();
    for (int n = 0; n < 260; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 300; w++) begin
        @(negedge i_clk);
        i_tx_done = 1'b0;
        if (o_tx_start) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        chk($sformatf("tx_start_timeout_byte%0d", n), 32'(0), 32'(1));
        return;
      end
      b = o_tx_data;
      chk($sformatf("dump_byte%0d", n), 32'(b), 32'(exp_q[n]));
      if (n == stop_at) begin
        #2 i_reset = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({o_write, o_enable, o_tx_start, o_state}), 32'(0));
        chk("rst_async_data", 32'({o_debug_addr, o_tx_data}), 32'(0));
        chk("rst_async_instr", o_instruction, 32'(0));
        return;
      end
      d = $urandom_range(dmax, dmin);
      for (int k = 0; k < d; k++) begin
        @(negedge i_clk);
        i_rx_data = CMD_LOAD;
        i_rx_done = (n == 10 && k == 0);
        if (o_tx_start || o_tx_data !== b || o_write || o_enable) bad++;
      end
      i_rx_done = 1'b0;
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = spur;
    end
    @(negedge i_clk);
    i_tx_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("dump_hold_stable", 32'(bad), 32'(0));
    chk("dump_tx_count", 32'(txs_cnt - t0), 32'(260));
    chk("dump_end_state", 32'(o_state), 32'(0));
  endtask

  task automatic load_words(input logic [31:0] words [$]);
    int base;
    base = wr_q.size();
    send_byte(CMD_LOAD, $urandom_range(3, 0));
    foreach (words[w]) begin
      for (int k = 3; k >= 0; k--) send_byte(words[w][k*8 +: 8], $urandom_range(3, 0));
    end
    repeat (2) @(negedge i_clk);
    chk("rand_load_count", 32'(wr_q.size() - base), 32'(words.size()));
    foreach (words[w]) begin
      if (base + w < wr_q.size()) chk($sformatf("rand_load_word%0d", w), wr_q[base + w], words[w]);
    end
    chk("rand_load_idle", 32'(o_state), 32'(0));
  endtask

  initial begin
    #3ms;
    failures++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t0;
    int kk;
    logic [31:0] wl [$];
    set_ident_tables();
    repeat (3) @(negedge i_clk);
    chk("reset_ctrl", 32'({o_write, o_enable, o_tx_start, o_state}), 32'(0));
    chk("reset_data", 32'({o_debug_addr, o_tx_data}), 32'(0));
    chk("reset_instr", o_instruction, 32'(0));
    i_reset = 1'b1;
    @(negedge i_clk);

    send_byte(CMD_LOAD, 1);
    send_byte(8'h20, 0); send_byte(8'h01, 2); send_byte(8'h00, 0); send_byte(8'h05, 0);
    @(negedge i_clk);
    chk("load_wr_count", 32'(wr_q.size()), 32'(1));
    chk("load_word", wr_q[0], 32'h2001_0005);
    chk("load_state", 32'(o_state), 32'(1));

    repeat (4) send_byte(8'hFF, 1);
    @(negedge i_clk);
    chk("halt_wr_count", 32'(wr_q.size()), 32'(2));
    chk("halt_word", wr_q[1], HALT_INST);
    chk("halt_state", 32'(o_state), 32'(0));
    send_byte(8'h99, 2);
    chk("junk_state", 32'(o_state), 32'(0));
    chk("junk_wr_count", 32'(wr_q.size()), 32'(2));

    e0 = en_cnt;
    send_byte(CMD_STEP, 0);
    do_dump(2, 4, 1'b0, -1);
    chk("step_enable_cycles", 32'(en_cnt - e0), 32'(1));

    e0 = en_cnt;
    send_byte(CMD_RUN, 0);
    repeat (10) @(negedge i_clk);
    i_halt = 1'b1;
    do_dump(2, 4, 1'b0, -1);
    chk("run_enable_cycles", 32'(en_cnt - e0), 32'(10));

    e0 = en_cnt;
    send_byte(CMD_RUN, 0);
    do_dump(2, 4, 1'b0, -1);
    chk("run_halted_enable", 32'(en_cnt - e0), 32'(0));
    i_halt = 1'b0;

    set_random_tables();
    send_byte(CMD_STEP, 0);
    do_dump(50, 50, 1'b1, -1);

    set_random_tables();
    send_byte(CMD_STEP, 0);
    do_dump(2, 4, 1'b1, 100);
    t0 = txs_cnt;
    e0 = en_cnt;
    repeat (4) @(negedge i_clk);
    chk("rst_hold_no_tx", 32'(txs_cnt - t0), 32'(0));
    chk("rst_hold_no_en", 32'(en_cnt - e0), 32'(0));
    i_reset = 1'b1;
    @(negedge i_clk);
    set_random_tables();
    send_byte(CMD_STEP, 0);
    do_dump(2, 4, 1'b0, -1);

    for (int it = 0; it < 4; it++) begin
      wl.delete();
      for (int w = 0; w < int'($urandom_range(3, 1)); w++) begin
        wl.push_back($urandom);
        if (wl[w] == HALT_INST) wl[w] = 32'h0;
      end
      wl.push_back(HALT_INST);
      load_words(wl);
      send_byte(8'h00 + 8'($urandom_range(8'h3F, 8'h00)), 1);
      chk("rand_noise_idle", 32'(o_state), 32'(0));

      set_random_tables();
      e0 = en_cnt;
      case ($urandom_range(3, 0))
        0: begin
          send_byte(CMD_STEP, 0);
          do_dump(2, 5, 1'($urandom_range(1, 0)), -1);
          chk("rand_step_en", 32'(en_cnt - e0), 32'(1));
        end
        1: begin
          i_halt = 1'b1;
          send_byte(CMD_STEP, 0);
          do_dump(2, 5, 1'($urandom_range(1, 0)), -1);
          chk("rand_step_halted_en", 32'(en_cnt - e0), 32'(0));
        end
        2: begin
          i_halt = 1'b1;
          send_byte(CMD_RUN, 0);
          do_dump(2, 5, 1'($urandom_range(1, 0)), -1);
          chk("rand_run_halted_en", 32'(en_cnt - e0), 32'(0));
        end
        default: begin
          kk = $urandom_range(20, 0);
          send_byte(CMD_RUN, 0);
          repeat (kk) @(negedge i_clk);
          i_halt = 1'b1;
          do_dump(2, 5, 1'($urandom_range(1, 0)), -1);
          chk("rand_run_en", 32'(en_cnt - e0), 32'(kk));
        end
      endcase
      i_halt = 1'b0;
    end

    chk("write_tx_exclusive", 32'(excl_bad), 32'(0));
    chk("enable_only_run_step", 32'(en_bad), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
